diad_trace_buffer: RTL and testbench
====================================

// Module: diad_trace_buffer
// PURPOSE
//  Synthesizable on-chip pipeline trace capture for the diad core.
//  - Records NUM_CH per-stage probe words (e.g. PC or instruction per stage), plus a timestamp, into a circular buffer of DEPTH entries.
//  - Supports trigger with programmable post-trigger count, or manual stop.
//  - Captured entries drain oldest-first over a valid/ready stream.
//  - Replaces $display-based stage dumps with a hardware mechanism usable on silicon and FPGA.
// PARAMETERS
//  NUM_CH  6   number of probe channels (one per pipeline stage)
//  DATA_W  24  width of each probe word
//  DEPTH   64  buffer entries; power of two, >=4
//  TS_W    16  timestamp (free-running tick) width
//  PTR_W   $clog2(DEPTH)  derived, not overridable
// PORTS
//  iw_clk       in   1                clock
//  iw_rst_n     in   1                reset, asynchronous, active-low
//  iw_sample_en in   1                probe data valid this cycle
//  iw_ch_data   in   NUM_CH*DATA_W    probe words, ch0 in LSBs
//  iw_mode      in   1                0=trigger mode, 1=free-run (trigger ignored)
//  iw_arm       in   1                pulse: start capture (IDLE only)
//  iw_trig      in   1                trigger event
//  iw_stop      in   1                pulse: force end of capture
//  iw_post_cnt  in   PTR_W            samples to record after the trigger sample
//  iw_rd_ready  in   1                consumer ready
//  ow_rd_valid  out  1                readout entry valid
//  ow_rd_data   out  NUM_CH*DATA_W    readout probe words
//  ow_rd_ts     out  TS_W             readout timestamp
//  ow_rd_last   out  1                final entry of the drain
//  ow_state     out  2                0=IDLE 1=ARMED 2=POST 3=READ
//  ow_count     out  PTR_W+1          valid entries held (saturates at DEPTH)
//  ow_overflow  out  1                oldest entries were overwritten
//  ow_trig_pos  out  PTR_W            buffer index of the trigger sample
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pointers/tick 0. Async assert; flops released on the clock edge after deassert.
//  Tick: TS_W counter increments every cycle, wraps; stored with each write.
//  IDLE
//   - iw_arm -> ARMED next cycle; clears wr_ptr, count, overflow, trig_pos.
//  ARMED and POST: each cycle with iw_sample_en
//   - write {tick, iw_ch_data} at wr_ptr; wr_ptr+1 mod DEPTH.
//   - if count<DEPTH: count+1; else overflow=1 (sticky until next arm).
//  ARMED, iw_mode=0, iw_trig
//   - trig_pos=wr_ptr; remaining=iw_post_cnt.
//   - If post_cnt=0 and sample_en: trigger sample written -> READ.
//   - If post_cnt=0 and no sample_en: -> READ without writing.
//   - Otherwise -> POST.
//  POST
//   - each write decrements remaining; write bringing it to 0 -> READ next cycle.
//   - iw_trig ignored.
//  iw_stop in ARMED or POST
//   - -> READ next cycle; a sample_en write in the same cycle is still written.
//   - stop wins over simultaneous trig.
//  READ
//   - sampling inhibited; arm/trig/stop ignored.
//   - rd_ptr starts at the oldest entry (wr_ptr if count=DEPTH, else 0).
//   - ow_rd_valid rises the cycle after entering READ (1-cycle RAM latency).
//   - transfer = valid & ready; data/ts/last held stable while valid & !ready.
//   - ow_rd_last is high with the count-th entry; after its transfer -> IDLE, count=0 (overflow and trig_pos kept).
//   - count=0 on entry: -> IDLE the next cycle; valid never asserted.
//   - no skipped or duplicated entries under any ready pattern.
//  iw_arm outside IDLE ignored; iw_rst_n low in any state aborts to IDLE immediately.
// TESTING (bench: NUM_CH=2 DATA_W=8 DEPTH=8 TS_W=8)
//  1 Reset
//    - stimulus: assert iw_rst_n=0 mid-run.
//    - response: all outputs 0, state=0 asynchronously, before the next clock edge.
//  2 Trigger capture
//    - stimulus: arm, mode=0, post_cnt=1; samples ch0=01..05; trig with sample 03.
//    - response: READ after sample 04; trig_pos=2; drain 01,02,03,04; last on 04; then IDLE.
//  3 Wrap
//    - stimulus: arm, mode=1; 11 samples 10..1A; stop.
//    - response: count=8, overflow=1; drain 13..1A; timestamps strictly increasing by 1.
//  4 Backpressure
//    - stimulus: drain 4 entries with ready=1,0,0,1,1,0,1.
//    - response: data stable during stalls; exactly 4 transfers in order.
//  5 Empty stop
//    - stimulus: arm then stop with no sample_en.
//    - response: state 1->3->0 over 2 cycles; rd_valid stays 0.
//  6 Stop/trig race
//    - stimulus: stop and trig in the same ARMED cycle with post_cnt=3.
//    - response: READ next cycle, no POST state.

Source files
------------

// File: rtl/diad_trace_buffer.sv
`default_nettype none
// ============================================================================
// diad_trace_buffer - circular pipeline trace capture, trigger/stop, stream drain
// Revision 1.0
// ============================================================================
module diad_trace_buffer #(
    parameter int NUM_CH = 6,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst_n,
    input  logic                     iw_sample_en,
    input  logic [NUM_CH*DATA_W-1:0] iw_ch_data,
    input  logic                     iw_mode,
    input  logic                     iw_arm,
    input  logic                     iw_trig,
    input  logic                     iw_stop,
    input  logic [PTR_W-1:0]         iw_post_cnt,
    input  logic                     iw_rd_ready,
    output logic                     ow_rd_valid,
    output logic [NUM_CH*DATA_W-1:0] ow_rd_data,
    output logic [TS_W-1:0]          ow_rd_ts,
    output logic                     ow_rd_last,
    output logic [1:0]               ow_state,
    output logic [PTR_W:0]           ow_count,
    output logic                     ow_overflow,
    output logic [PTR_W-1:0]         ow_trig_pos
);

    localparam int ENT_W = TS_W + NUM_CH*DATA_W;
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_CNT   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
    localparam logic [TS_W-1:0]  ONE_TS    = TS_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        READ  = 2'd3
    } state_t;

    logic [ENT_W-1:0] mem [DEPTH];

    state_t           state;
    logic [TS_W-1:0]  tick;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] remaining;
    logic [PTR_W:0]   rd_left;

    logic             capturing;
    logic             wr_en;
    logic             full;
    logic [PTR_W:0]   count_nxt;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic             go_read;
    logic             fetch;
    logic             read_done;

    always_comb begin
        capturing  = (state == ARMED) || (state == POST);
        wr_en      = capturing && iw_sample_en;
        full       = (ow_count == DEPTH_CNT);
        count_nxt  = (wr_en && !full) ? ow_count + ONE_CNT : ow_count;
        wr_ptr_nxt = wr_en ? wr_ptr + ONE_PTR : wr_ptr;
        go_read    = (capturing && iw_stop)
                  || (state == ARMED && !iw_mode && iw_trig && iw_post_cnt == '0)
                  || (state == POST && wr_en && remaining == ONE_PTR);
        // Output register doubles as the single RAM-latency stage: refill it
        // whenever it is empty or being consumed this cycle.
        fetch      = (state == READ) && (rd_left != '0) && (!ow_rd_valid || iw_rd_ready);
        read_done  = (state == READ)
                  && ((ow_rd_valid && iw_rd_ready && ow_rd_last) || (!ow_rd_valid && rd_left == '0));
    end

    always_ff @(posedge iw_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {tick, iw_ch_data};
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state       <= IDLE;
            tick        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            remaining   <= '0;
            rd_left     <= '0;
            ow_rd_valid <= 1'b0;
            ow_rd_data  <= '0;
            ow_rd_ts    <= '0;
            ow_rd_last  <= 1'b0;
            ow_count    <= '0;
            ow_overflow <= 1'b0;
            ow_trig_pos <= '0;
        end else begin
            tick <= tick + ONE_TS;

            if (wr_en) begin
                wr_ptr   <= wr_ptr_nxt;
                ow_count <= count_nxt;
                if (full) begin
                    ow_overflow <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (iw_arm) begin
                        state       <= ARMED;
                        wr_ptr      <= '0;
                        ow_count    <= '0;
                        ow_overflow <= 1'b0;
                        ow_trig_pos <= '0;
                    end
                end
                ARMED: begin
                    if (!iw_stop && !iw_mode && iw_trig) begin
                        ow_trig_pos <= wr_ptr;
                        remaining   <= iw_post_cnt;
                        if (iw_post_cnt != '0) begin
                            state <= POST;
                        end
                    end
                end
                POST: begin
                    if (wr_en) begin
                        remaining <= remaining - ONE_PTR;
                    end
                end
                READ: begin
                    if (fetch) begin
                        {ow_rd_ts, ow_rd_data} <= mem[rd_ptr];
                        rd_ptr      <= rd_ptr + ONE_PTR;
                        rd_left     <= rd_left - ONE_CNT;
                        ow_rd_valid <= 1'b1;
                        ow_rd_last  <= (rd_left == ONE_CNT);
                    end else if (ow_rd_valid && iw_rd_ready) begin
                        ow_rd_valid <= 1'b0;
                        ow_rd_last  <= 1'b0;
                    end
                    if (read_done) begin
                        state    <= IDLE;
                        ow_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Oldest entry sits at the write pointer once the ring has filled.
            if (go_read) begin
                state   <= READ;
                rd_ptr  <= (count_nxt == DEPTH_CNT) ? wr_ptr_nxt : '0;
                rd_left <= count_nxt;
            end
        end
    end

    assign ow_state = state;

endmodule
`default_nettype wire

// File: tb/tb_diad_trace_buffer.sv
`default_nettype none
// ============================================================================
// tb_diad_trace_buffer - directed self-checking bench for diad_trace_buffer
// Revision 1.0
// ============================================================================
module tb_diad_trace_buffer;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [15:0] ch_data;
    logic        mode;
    logic        arm;
    logic        trig;
    logic        stop;
    logic [2:0]  post_cnt;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [7:0]  rd_ts;
    logic        rd_last;
    logic [1:0]  state;
    logic [3:0]  count;
    logic        overflow;
    logic [2:0]  trig_pos;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    diad_trace_buffer #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W)
    ) dut (
        .iw_clk       (clk),
        .iw_rst_n     (rst_n),
        .iw_sample_en (sample_en),
        .iw_ch_data   (ch_data),
        .iw_mode      (mode),
        .iw_arm       (arm),
        .iw_trig      (trig),
        .iw_stop      (stop),
        .iw_post_cnt  (post_cnt),
        .iw_rd_ready  (rd_ready),
        .ow_rd_valid  (rd_valid),
        .ow_rd_data   (rd_data),
        .ow_rd_ts     (rd_ts),
        .ow_rd_last   (rd_last),
        .ow_state     (state),
        .ow_count     (count),
        .ow_overflow  (overflow),
        .ow_trig_pos  (trig_pos)
    );

    function automatic logic [15:0] entry(input logic [7:0] v);
        return {v + 8'h80, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},    32'(rd_valid), 0);
        chk({tag, "_data"},     32'(rd_data),  0);
        chk({tag, "_ts"},       32'(rd_ts),    0);
        chk({tag, "_last"},     32'(rd_last),  0);
        chk({tag, "_state"},    32'(state),    0);
        chk({tag, "_count"},    32'(count),    0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_trig_pos"}, 32'(trig_pos), 0);
    endtask

    initial begin
        logic [7:0]  prev_ts;
        logic [7:0]  exp_ts;
        logic [15:0] held;
        int          k;
        int          pat [7] = '{1, 0, 0, 1, 1, 0, 1};

        rst_n = 1'b0; sample_en = 1'b0; ch_data = '0; mode = 1'b0;
        arm = 1'b0; trig = 1'b0; stop = 1'b0; post_cnt = '0; rd_ready = 1'b0;
        prev_ts = '0; held = '0; k = 0;
        step(); step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk("post_reset_state", 32'(state), 0);

        // Trigger capture: post_cnt=1, trigger on sample 03
        mode = 1'b0; post_cnt = 3'd1; arm = 1'b1;
        step(); arm = 1'b0;
        chk("t2_armed", 32'(state), 1);
        for (int i = 1; i <= 4; i++) begin
            sample_en = 1'b1; ch_data = entry(8'(i)); trig = (i == 3);
            step();
            trig = 1'b0;
            if (i == 3) begin
                chk("t2_post", 32'(state), 2);
                chk("t2_trig_pos", 32'(trig_pos), 2);
            end
        end
        chk("t2_read", 32'(state), 3);
        chk("t2_valid_late", 32'(rd_valid), 0);
        sample_en = 1'b1; ch_data = entry(8'h05); rd_ready = 1'b1;
        step();
        sample_en = 1'b0;
        chk("t2_count_inhibit", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_valid", 32'(rd_valid), 1);
            chk("t2_data", 32'(rd_data), 32'(entry(8'(i + 1))));
            chk("t2_last", 32'(rd_last), 32'(i == 3));
            if (i > 0) begin
                exp_ts = prev_ts + 8'd1;
                chk("t2_ts", 32'(rd_ts), 32'(exp_ts));
            end
            prev_ts = rd_ts;
            step();
        end
        chk("t2_idle", 32'(state), 0);
        chk("t2_valid_off", 32'(rd_valid), 0);
        chk("t2_count_clr", 32'(count), 0);
        chk("t2_trig_kept", 32'(trig_pos), 2);

        // Wrap in free-run; a trigger here must be ignored
        rd_ready = 1'b0; mode = 1'b1; arm = 1'b1;
        step(); arm = 1'b0;
        chk("t3_armed", 32'(state), 1);
        for (int i = 0; i < 11; i++) begin
            sample_en = 1'b1; ch_data = entry(8'h10 + 8'(i)); trig = (i == 2);
            step();
            trig = 1'b0;
            if (i == 2) chk("t3_trig_ignored", 32'(state), 1);
        end
        sample_en = 1'b0; stop = 1'b1;
        step(); stop = 1'b0;
        chk("t3_read", 32'(state), 3);
        chk("t3_count", 32'(count), 8);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_valid_late", 32'(rd_valid), 0);
        rd_ready = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            chk("t3_valid", 32'(rd_valid), 1);
            chk("t3_data", 32'(rd_data), 32'(entry(8'h13 + 8'(i))));
            chk("t3_last", 32'(rd_last), 32'(i == 7));
            if (i > 0) begin
                exp_ts = prev_ts + 8'd1;
                chk("t3_ts", 32'(rd_ts), 32'(exp_ts));
            end
            prev_ts = rd_ts;
            step();
        end
        chk("t3_idle", 32'(state), 0);
        chk("t3_overflow_kept", 32'(overflow), 1);

        // Backpressure drain of 4 entries
        rd_ready = 1'b0; arm = 1'b1;
        step(); arm = 1'b0;
        chk("t4_ovf_cleared", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            sample_en = 1'b1; ch_data = entry(8'h21 + 8'(i));
            step();
        end
        sample_en = 1'b0; stop = 1'b1;
        step(); stop = 1'b0;
        chk("t4_read", 32'(state), 3);
        chk("t4_count", 32'(count), 4);
        step();
        for (int j = 0; j < 7; j++) begin
            if (j > 0 && pat[j-1] == 0) chk("t4_stable", 32'(rd_data), 32'(held));
            chk("t4_valid", 32'(rd_valid), 1);
            chk("t4_data", 32'(rd_data), 32'(entry(8'h21 + 8'(k))));
            chk("t4_last", 32'(rd_last), 32'(k == 3));
            held = rd_data;
            rd_ready = (pat[j] != 0);
            step();
            if (pat[j] != 0) k++;
        end
        rd_ready = 1'b0;
        chk("t4_idle", 32'(state), 0);
        chk("t4_valid_off", 32'(rd_valid), 0);

        // Empty stop
        mode = 1'b0; arm = 1'b1;
        step(); arm = 1'b0;
        chk("t5_armed", 32'(state), 1);
        stop = 1'b1;
        step(); stop = 1'b0;
        chk("t5_read", 32'(state), 3);
        chk("t5_valid0", 32'(rd_valid), 0);
        step();
        chk("t5_idle", 32'(state), 0);
        chk("t5_valid1", 32'(rd_valid), 0);

        // Stop and trigger together: stop wins, sample still written
        post_cnt = 3'd3; arm = 1'b1;
        step(); arm = 1'b0;
        stop = 1'b1; trig = 1'b1; sample_en = 1'b1; ch_data = entry(8'h31);
        step();
        stop = 1'b0; trig = 1'b0; sample_en = 1'b0;
        chk("t6_read", 32'(state), 3);
        chk("t6_count", 32'(count), 1);
        rd_ready = 1'b1;
        step();
        chk("t6_data", 32'(rd_data), 32'(entry(8'h31)));
        chk("t6_last", 32'(rd_last), 1);
        step();
        chk("t6_idle", 32'(state), 0);
        rd_ready = 1'b0;

        // Asynchronous reset in the middle of a drain
        post_cnt = 3'd0; arm = 1'b1;
        step(); arm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample_en = 1'b1; ch_data = entry(8'h40 + 8'(i)); trig = (i == 9);
            step();
        end
        sample_en = 1'b0; trig = 1'b0;
        chk("t1_read", 32'(state), 3);
        chk("t1_count", 32'(count), 8);
        chk("t1_overflow", 32'(overflow), 1);
        chk("t1_trig_pos", 32'(trig_pos), 1);
        step();
        chk("t1_valid", 32'(rd_valid), 1);
        chk("t1_oldest", 32'(rd_data), 32'(entry(8'h42)));
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("t1_after_release", 32'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
